// File: rtl/knap_pkg.sv
// Shared types and sizing for the knapsack DP engine.
package knap_pkg;
    localparam int IDX_W  = 7;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int MAX_CAP = 64;
    localparam logic [IDX_W-1:0] MAX_CAP_IDX = IDX_W'(MAX_CAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_ITEM,
        S_RD_CUR,
        S_RD_PREV,
        S_WR,
        S_FIN_RD,
        S_FIN_CAP
    } state_t;
endpackage

// File: rtl/knap_max_add.sv
// Candidate value prev+value (saturating when KNAP_SAT_ADD_EN is defined,
// wrapping otherwise) and unsigned max against cur; ties keep cur.
module knap_max_add
    import knap_pkg::*;
(
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] best
);
    logic [DATA_W-1:0] sum;

`ifdef KNAP_SAT_ADD_EN
    logic [DATA_W:0] sum_full;
    assign sum_full = {1'b0, prev} + {1'b0, value};
    assign sum = sum_full[DATA_W] ? '1 : sum_full[DATA_W-1:0];
`else
    assign sum = prev + value;
`endif

    assign best = (sum > cur) ? sum : cur;
endmodule

// File: rtl/knapsack_dp_engine.sv
// 0/1 knapsack DP sequencer driving a 64-entry table; build option KNAP_SAT_ADD_EN.
// Handshake: an item transfers on a clk edge where item_valid && item_ready.
module knapsack_dp_engine
    import knap_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  capacity,
    input  logic              item_valid,
    output logic              item_ready,
    input  logic [IDX_W-1:0]  item_weight,
    input  logic [DATA_W-1:0] item_value,
    input  logic              item_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            dbg_state
);
    state_t            state, state_d;
    logic [IDX_W-1:0]  w, w_d, cap, cap_d, wt, wt_d, idx;
    logic [DATA_W-1:0] val, val_d, cur, cur_d, result_q, result_d, best;
    logic              last, last_d, prev_zero, prev_zero_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            w         <= '0;
            cap       <= '0;
            wt        <= '0;
            val       <= '0;
            last      <= 1'b0;
            cur       <= '0;
            prev_zero <= 1'b0;
            result_q  <= '0;
        end else begin
            state     <= state_d;
            w         <= w_d;
            cap       <= cap_d;
            wt        <= wt_d;
            val       <= val_d;
            last      <= last_d;
            cur       <= cur_d;
            prev_zero <= prev_zero_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d     = state;
        w_d         = w;
        cap_d       = cap;
        wt_d        = wt;
        val_d       = val;
        last_d      = last;
        cur_d       = cur;
        prev_zero_d = prev_zero;
        result_d    = result_q;
        case (state)
            S_IDLE: if (start && capacity != '0) begin
                cap_d   = (capacity > MAX_CAP_IDX) ? MAX_CAP_IDX : capacity;
                w_d     = IDX_W'(1);
                state_d = S_CLEAR;
            end
            S_CLEAR: if (w == cap) state_d = S_WAIT_ITEM;
                     else          w_d = w + IDX_W'(1);
            S_WAIT_ITEM: if (item_valid) begin
                wt_d   = item_weight;
                val_d  = item_value;
                last_d = item_last;
                if (item_weight != '0 && item_weight <= cap) begin
                    w_d     = cap;
                    state_d = S_RD_CUR;
                end else if (item_last) begin
                    state_d = S_FIN_RD;
                end
            end
            S_RD_CUR: state_d = S_RD_PREV;
            S_RD_PREV: begin
                cur_d       = mem_rdata;
                prev_zero_d = (w == wt);
                state_d     = S_WR;
            end
            S_WR: if (w == wt) state_d = last ? S_FIN_RD : S_WAIT_ITEM;
                  else begin
                      w_d     = w - IDX_W'(1);
                      state_d = S_RD_CUR;
                  end
            S_FIN_RD: state_d = S_FIN_CAP;
            S_FIN_CAP: begin
                result_d = mem_rdata;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    knap_max_add u_max_add (
        .cur   (cur),
        .prev  (prev_zero ? '0 : mem_rdata),
        .value (val),
        .best  (best)
    );

    // Table strobes are decoded from the state registers only.
    always_comb begin
        idx = '0;
        case (state)
            S_CLEAR, S_RD_CUR, S_WR: idx = w;
            S_RD_PREV:               idx = w - wt;
            S_FIN_RD:                idx = cap;
            default:                 idx = '0;
        endcase
    end

    assign mem_addr   = {{(ADDR_W-IDX_W){1'b0}}, idx};
    assign mem_rd_en  = (state == S_RD_CUR) || (state == S_FIN_RD) ||
                        (state == S_RD_PREV && w != wt);
    assign mem_wr_en  = (state == S_CLEAR) || (state == S_WR);
    assign mem_wdata  = (state == S_WR) ? best : '0;
    assign item_ready = (state == S_WAIT_ITEM);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN_CAP);
    assign result     = done ? mem_rdata : result_q;
    assign dbg_state  = state;
endmodule

// File: tb/tb_knapsack_dp_engine.sv
// Directed bench for knapsack_dp_engine with a table memory and knapsack model.
module tb_knapsack_dp_engine;
    import knap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  capacity = '0;
    logic        item_valid = 1'b0;
    logic        item_ready;
    logic [6:0]  item_weight = '0;
    logic [31:0] item_value = '0;
    logic        item_last = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [15:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    state_t      dbg_state;

    knapsack_dp_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .capacity(capacity),
        .item_valid(item_valid), .item_ready(item_ready),
        .item_weight(item_weight), .item_value(item_value), .item_last(item_last),
        .busy(busy), .done(done), .result(result),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Table memory: registered read data, zero when no read was issued.
    logic [31:0] mem [0:127];
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[6:0]] <= mem_wdata;
        mem_rdata <= mem_rd_en ? mem[mem_addr[6:0]] : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Knapsack reference
    int          iw[$];
    logic [31:0] iv[$];
    logic [31:0] mdp [0:64];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_knap(input int capc);
        longint cand;
        for (int i = 0; i <= 64; i++) mdp[i] = '0;
        foreach (iw[k]) begin
            if (iw[k] >= 1 && iw[k] <= capc) begin
                for (int x = capc; x >= iw[k]; x--) begin
                    cand = longint'(mdp[x - iw[k]]) + longint'(iv[k]);
`ifdef KNAP_SAT_ADD_EN
                    if (cand > 64'hFFFF_FFFF) cand = 64'hFFFF_FFFF;
`else
                    cand = cand & 64'hFFFF_FFFF;
`endif
                    if (cand > longint'(mdp[x])) mdp[x] = cand[31:0];
                end
            end
        end
        return mdp[capc];
    endfunction

    // Compare process: timing and values of done/busy/result against the model
    logic chk_en = 1'b0;
    int   start_edge = 0;
    int   exp_done_cyc = 0;
    int   cap_c = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done", {31'b0, done}, {31'b0, cyc == exp_done_cyc});
            chk("busy", {31'b0, busy}, {31'b0, cyc >= start_edge && cyc <= exp_done_cyc});
            if (cyc >= start_edge && cyc < start_edge + cap_c)
                chk("ready_in_clear", {31'b0, item_ready}, 32'h0);
            if (cyc == exp_done_cyc && exp_q.size() > 0)
                chk("result", result, exp_q.pop_front());
        end
    end

    task automatic run(input int cap_in, input logic [31:0] lit, input bit poke);
        int capc, t, n, b;
        logic [31:0] m;
        capc = (cap_in > 64) ? 64 : cap_in;
        m = model_knap(capc);
        chk("model_literal", m, lit);
        exp_q.push_back(m);
        n = iw.size();
        t = 0;
        foreach (iw[k]) t += (iw[k] >= 1 && iw[k] <= capc) ? 1 + 3 * (capc - iw[k] + 1) : 1;
        @(negedge clk);
        capacity    = 7'(cap_in);
        start       = 1'b1;
        item_weight = 7'(iw[0]);
        item_value  = iv[0];
        item_last   = (n == 1);
        item_valid  = 1'b1;
        start_edge   = cyc + 1;
        cap_c        = capc;
        exp_done_cyc = start_edge + capc + t + 1;
        chk_en       = 1'b1;
        @(posedge clk); #1;
        if (poke) begin
            capacity = 7'd9;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            item_weight = 7'(iw[i]);
            item_value  = iv[i];
            item_last   = (i == n - 1);
            item_valid  = 1'b1;
            b = 0;
            @(negedge clk);
            while (!item_ready && b < 500) begin @(negedge clk); b++; end
            if (!item_ready) begin
                compared++; mismatched++;
                $display("FAIL item_accept_timeout: item %0d got ready=0 expected 1", i);
                break;
            end
            @(posedge clk); #1;
        end
        item_valid = 1'b0;
        item_last  = 1'b0;
        while (cyc <= exp_done_cyc + 2) @(negedge clk);
        chk_en = 1'b0;
        for (int x = 1; x <= capc; x++) chk("dp_table", mem[x], mdp[x]);
    endtask

    initial begin
        logic [31:0] lit_dp [1:5];
        int e;
        lit_dp[1] = 0; lit_dp[2] = 3; lit_dp[3] = 4; lit_dp[4] = 5; lit_dp[5] = 7;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, item_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("rst_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_result", result, 32'h0);
        rst_n = 1'b1;

        // Basic four-item run
        iw = '{2, 3, 4, 5}; iv = '{3, 4, 5, 6};
        run(5, 32'd7, 1'b0);
        for (int x = 1; x <= 5; x++) chk("dp_literal", mem[x], lit_dp[x]);

        // Oversized single item is skipped
        iw = '{7}; iv = '{9};
        run(5, 32'd0, 1'b0);

        // Addition overflow
        iw = '{1, 1}; iv = '{32'hFFFF_FFF0, 32'h20};
`ifdef KNAP_SAT_ADD_EN
        run(2, 32'hFFFF_FFFF, 1'b0);
`else
        run(2, 32'hFFFF_FFF0, 1'b0);
`endif

        // start held while busy, zero-weight item skipped
        iw = '{1, 2, 0, 3}; iv = '{10, 25, 99, 30};
        run(4, 32'd40, 1'b1);

        // Capacity clamp and weight above capacity
        iw = '{70, 64, 30, 34}; iv = '{5, 1000, 7, 8};
        run(100, 32'd1000, 1'b0);

        // start with capacity 0 is ignored
        @(negedge clk);
        capacity = 7'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cap0_busy", {31'b0, busy}, 32'h0);
        chk("cap0_wr_en", {31'b0, mem_wr_en}, 32'h0);

        // Reset pulse during RD_PREV: cap=5, item (2,3 last)
        @(negedge clk);
        capacity = 7'd5; start = 1'b1;
        item_weight = 7'd2; item_value = 32'd3; item_last = 1'b1; item_valid = 1'b1;
        e = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < e + 7) @(negedge clk);
        chk("mid_rd_prev_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        item_valid = 1'b0; item_last = 1'b0;
        @(negedge clk);
        chk("mrst_ready", {31'b0, item_ready}, 32'h0);
        chk("mrst_busy", {31'b0, busy}, 32'h0);
        chk("mrst_done", {31'b0, done}, 32'h0);
        chk("mrst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        chk("mrst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("mrst_addr", {16'b0, mem_addr}, 32'h0);
        chk("mrst_wdata", mem_wdata, 32'h0);
        chk("mrst_result", result, 32'h0);
        rst_n = 1'b1;

        iw = '{1}; iv = '{5};
        run(3, 32'd5, 1'b0);

        chk("exp_q_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
